// File: rtl/count_req_arbiter.sv
// count_req_arbiter: round-robin arbiter sharing one up/down counter among NUM_REQ requesters.
// Define ARB_PRIO0_EN to give requester 0 absolute priority over the round robin.
module count_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_dir,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctr_up_down,
  output logic [DATA_W-1:0]         ctr_add_val,
  input  logic [DATA_W-1:0]         ctr_count,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_count,
  output logic                      busy
);
  logic [ID_W-1:0]   ptr_q, ptr_d, win, nxt, s1_id_q, s2_id_q;
  logic [ID_W:0]     idx;
  logic              found, gnt, s1_vld_q, s2_vld_q, s1_dir_q;
  logic [DATA_W-1:0] s1_val_q;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(o);
      idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
`ifdef ARB_PRIO0_EN
    win   = req_valid[0] ? '0 : win;
    found = found | req_valid[0];
    gnt   = found && !reset;
    nxt   = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    ptr_d = (gnt && !req_valid[0]) ? nxt : ptr_q;
`else
    gnt   = found && !reset;
    nxt   = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    ptr_d = gnt ? nxt : ptr_q;
`endif
    req_ready = gnt ? (NUM_REQ'(1) << win) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_dir_q <= 1'b0;
      s1_val_q <= '0;
      s1_id_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      s1_vld_q <= gnt;
      s1_dir_q <= gnt & req_dir[win];
      s1_val_q <= gnt ? req_val[win*DATA_W +: DATA_W] : '0;
      s1_id_q  <= gnt ? win : s1_id_q;
      s2_vld_q <= s1_vld_q;
      s2_id_q  <= s1_vld_q ? s1_id_q : s2_id_q;
    end
  end
  // idle stage 1 holds zero step so the counter keeps its value
  assign ctr_up_down = s1_dir_q;
  assign ctr_add_val = s1_val_q;
  assign rsp_valid   = s2_vld_q;
  assign rsp_id      = s2_id_q;
  assign rsp_count   = s2_vld_q ? ctr_count : '0;
  assign busy        = s1_vld_q | s2_vld_q;
endmodule
